// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux between requesters A-D and
// presents the winning word on a registered valid/ready channel.
module rr_mux_arbiter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   output logic [3:0]       ack,
   output logic [3:0]       grant,
   output logic [1:0]       select,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e           r_state;
   logic [1:0]       r_ptr;
   logic [3:0]       r_grant;
   logic [1:0]       r_select;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   logic             w_found;
   logic [1:0]       w_win;
   logic [1:0]       w_idx;
   logic [WIDTH-1:0] w_mux;
   logic             w_xfer;

   // Scan req starting at the pointer; the first set bit wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = r_ptr;
      w_idx   = r_ptr;
      for (int k = 0; k < 4; k++) begin
         w_idx = r_ptr + 2'(k);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_comb begin
      w_mux = A;
      unique case (w_win)
         2'd0: w_mux = A;
         2'd1: w_mux = B;
         2'd2: w_mux = C;
         2'd3: w_mux = D;
      endcase
   end

   assign w_xfer = r_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= StIdle;
         r_ptr    <= 2'd0;
         r_grant  <= 4'd0;
         r_select <= 2'd0;
         r_data   <= '0;
         r_valid  <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_select <= w_win;
                  r_grant  <= 4'b0001 << w_win;
                  r_data   <= w_mux;
                  r_valid  <= 1'b1;
                  r_state  <= StBusy;
               end
            end
            StBusy: begin
               if (w_xfer) begin
                  r_ptr   <= r_select + 2'd1;
                  r_grant <= 4'd0;
                  r_valid <= 1'b0;
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Ack follows the grant only during the transfer cycle.
   assign ack       = w_xfer ? r_grant : 4'd0;
   assign grant     = r_grant;
   assign select    = r_select;
   assign out_data  = r_data;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter with hand-computed expectations.
module tb_rr_mux_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] A, B, C, D;
   logic [3:0] ack;
   logic [3:0] grant;
   logic [1:0] select;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready;

   int checks;
   int errors;

   rr_mux_arbiter #(.WIDTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .ack       (ack),
      .grant     (grant),
      .select    (select),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Winners expected with all four requests held after reset.
   logic [1:0] exp_sel [5];
   logic [3:0] exp_dat [5];

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0; req = 4'b0; out_ready = 1'b0;
      A = 4'b0000; B = 4'b0101; C = 4'b1010; D = 4'b1111;
      exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2;
      exp_sel[3] = 2'd3; exp_sel[4] = 2'd0;
      exp_dat[0] = 4'b0000; exp_dat[1] = 4'b0101; exp_dat[2] = 4'b1010;
      exp_dat[3] = 4'b1111; exp_dat[4] = 4'b0000;

      // Reset state
      do_reset();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_select", 32'(select), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);

      // 1: single request from B
      req = 4'b0010; out_ready = 1'b1;
      tick();
      check("t1_select", 32'(select), 32'h1);
      check("t1_grant", 32'(grant), 32'h2);
      check("t1_data", 32'(out_data), 32'h5);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_ack", 32'(ack), 32'h2);
      req = 4'b0;
      tick();
      check("t1_valid_after", 32'(out_valid), 32'd0);
      check("t1_ack_after", 32'(ack), 32'd0);

      // 2: all requesting, fair rotation from a fresh pointer
      do_reset();
      req = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t2_select", 32'(select), 32'(exp_sel[i]));
         check("t2_data", 32'(out_data), 32'(exp_dat[i]));
         check("t2_valid", 32'(out_valid), 32'd1);
         tick();
         check("t2_idle", 32'(out_valid), 32'd0);
      end
      req = 4'b0;
      tick();

      // 3: C held with downstream stalled; data frozen despite input change
      req = 4'b0100; out_ready = 1'b0;
      tick();
      check("t3_select", 32'(select), 32'h2);
      C = 4'b0011;
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_data", 32'(out_data), 32'hA);
         check("t3_hold_valid", 32'(out_valid), 32'd1);
         check("t3_hold_ack", 32'(ack), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("t3_ack", 32'(ack), 32'h4);
      req = 4'b0;
      tick();
      check("t3_ack_once", 32'(ack), 32'd0);
      check("t3_valid_done", 32'(out_valid), 32'd0);
      C = 4'b1010;

      // 4: serve D so pointer wraps to A, then A beats D, then D
      req = 4'b1000;
      tick();
      check("t4_d_select", 32'(select), 32'h3);
      req = 4'b0;
      tick();
      req = 4'b1001;
      tick();
      check("t4_a_select", 32'(select), 32'h0);
      check("t4_a_grant", 32'(grant), 32'h1);
      req = 4'b1000;
      tick();
      check("t4_gap", 32'(out_valid), 32'd0);
      tick();
      check("t4_d2_select", 32'(select), 32'h3);
      check("t4_d2_data", 32'(out_data), 32'hF);
      req = 4'b0;
      tick();

      // 5: reset while busy and stalled; pointer returns to A
      req = 4'b0010; out_ready = 1'b0;
      tick();
      check("t5_busy_select", 32'(select), 32'h1);
      req = 4'b0;
      do_reset();
      check("t5_valid", 32'(out_valid), 32'd0);
      check("t5_grant", 32'(grant), 32'd0);
      check("t5_data", 32'(out_data), 32'd0);
      check("t5_select", 32'(select), 32'd0);
      req = 4'b1100; out_ready = 1'b1;
      tick();
      check("t5_cd_select", 32'(select), 32'h2);
      check("t5_cd_data", 32'(out_data), 32'hA);
      req = 4'b0;
      tick();

      // 6: idle with out_ready toggling; select holds last winner
      for (int i = 0; i < 10; i++) begin
         out_ready = i[0];
         #1;
         check("t6_valid", 32'(out_valid), 32'd0);
         check("t6_ack", 32'(ack), 32'd0);
         check("t6_grant", 32'(grant), 32'd0);
         tick();
      end
      check("t6_select_hold", 32'(select), 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one parameterized 4x1 multiplexer path between four requesters A–D.
- Samples the request lines, picks a winner fairly, and drives the mux select.
- Registers the selected word onto a single valid/ready output channel.
- Returns a one-cycle acknowledge to the winning requester when the word is consumed downstream.

Parameters:
- WIDTH, 4, data width of each requester word and of out_data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request lines; bit 0=A, 1=B, 2=C, 3=D.
- A  input  WIDTH  requester A data.
- B  input  WIDTH  requester B data.
- C  input  WIDTH  requester C data.
- D  input  WIDTH  requester D data.
- ack  output  4  one-hot acknowledge; high for exactly the transfer cycle.
- grant  output  4  one-hot current owner; 0 when idle.
- select  output  2  mux select of the current/last winner.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts out_data when high with out_valid.

Behaviour:
- Reset: clk and reset are one clock, synchronous active-high reset, as already decided.
  - On any edge with reset=1: state=IDLE, grant=0, select=0, out_data=0, out_valid=0, ack=0, priority pointer ptr=0 (A highest).
  - Reset overrides an in-flight transfer; the held word is dropped and no ack is issued.
- States:
  - IDLE: grant=0, out_valid=0. At an edge with req!=0, choose the first set bit scanning ptr, ptr+1, ... modulo 4.
    - Register select=winner, grant=onehot(winner), out_data=mux(winner), out_valid=1. Go to BUSY.
    - If req=0, stay in IDLE; select keeps its last value.
  - BUSY: out_valid=1; grant, select and out_data are frozen.
    - Later changes on A–D or req do not alter out_data.
    - While out_ready=0, hold indefinitely (no timeout).
    - Transfer cycle = out_valid & out_ready. During it, ack = grant combinationally.
    - At the end of the transfer edge: ptr=select+1 mod 4 (wraps 3->0), grant=0, out_valid=0, return to IDLE.
- Latency and throughput:
  - Request sampled at edge N produces out_valid=1 after edge N.
  - After a transfer there is one mandatory IDLE cycle, so maximum throughput is one word per 2 cycles.
- Requester contract: hold req high until ack is seen. Deassert req within 1 cycle after ack unless it has another word. A req dropped before grant is simply not considered.
- Simultaneous requests: only ptr rotation decides the winner; no fixed priority beyond reset.
- Fairness: with all four req held continuously, grant order is A,B,C,D,A,...
- Ack is never asserted while out_valid=0. At most one ack bit is ever high.
- out_ready is ignored in IDLE.

Test Plan:
1. Reset, then A=0000, B=0101, C=1010, D=1111, req=0010, out_ready=1.
   - Cycle after the sampling edge: select=01, grant=0010, out_data=0101, out_valid=1, ack=0010.
   - Next cycle: out_valid=0.
2. req=1111 held, out_ready=1, same data.
   - out_data sequence 0000,0101,1010,1111,0000 on every second cycle.
   - select sequence 00,01,10,11,00 (pointer wrap).
3. req=0100 granted with out_ready=0 for 5 cycles, and C changed to 0011 mid-hold.
   - out_data stays 1010, out_valid stays 1, ack stays 0.
   - When out_ready=1: ack=0100 for one cycle only.
4. After D is served (ptr=0), req=1001 with out_ready=1.
   - A wins (select=00). Then, with req=1000 still held, D wins (select=11).
5. Assert reset while BUSY with out_ready=0.
   - Next edge: out_valid=0, grant=0, out_data=0, select=0.
   - Then req=1100 yields select=10 (ptr reset to 0, C before D).
6. req=0 for 10 cycles with out_ready toggling.
   - out_valid=0, ack=0, grant=0 throughout.
